led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Command-driven controller that sequences the 4-bit `led` bank of the Colorlight 5A-75E blink design through fixed patterns. It sits between control logic and the LED pins. It accepts one pattern command at a time over a valid/ready handshake, then plays the pattern for a programmed number of repetitions or until aborted. At the end it pulses `done`. An internal prescaler derives the step rate from the board clock.

## Interface
- `TICK_DIV`, default 6_250_000: clock cycles per pattern step (25 MHz → 4 steps/s); must be ≥ 2.
- `LED_W`, default 4: LED bank width; the patterns are defined for 4 only.
- `clk` input 1: system clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command (IDLE only).
- `cmd_mode` input 2: pattern select (0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT).
- `cmd_reps` input 8: full pattern periods to play; 0 = continuous until abort.
- `abort` input 1: stop current pattern (level, sampled each cycle).
- `busy` output 1: high in RUN and FINISH.
- `done` output 1: one-cycle pulse in FINISH.
- `led` output LED_W: registered LED drive, 1 = on.

## Operation
- States:
  - IDLE: `led`=0, `cmd_ready`=1.
  - RUN: pattern playing.
  - FINISH: one cycle, `done`=1, `led`=0.
- Transitions:
  - IDLE→RUN on `cmd_valid && cmd_ready`; `cmd_mode` and `cmd_reps` are latched.
  - RUN→FINISH on `abort`, or on the last tick of the last period when reps≠0.
  - FINISH→IDLE unconditionally.
- Patterns, listed per step (period length in brackets):
  - BLINK [2]: 0000, 1111.
  - CHASE [4]: 0001, 0010, 0100, 1000.
  - BOUNCE [6]: 0001, 0010, 0100, 1000, 0100, 0010.
  - COUNT [16]: binary 0000..1111.
- Step index: 4 bits, cleared on accept.
  - On each tick in RUN it advances; at period end it wraps to 0.
  - At period wrap, the repetition counter (8 bits, loaded with `cmd_reps`) decrements.
  - When the counter reaches 0 with reps≠0 → FINISH.
  - With reps=0 the counter is never decremented; the pattern wraps forever.
- Prescaler: counts 0..TICK_DIV-1; `tick` when count = TICK_DIV-1.
  - Held at 0 outside RUN and cleared on accept, so every step lasts exactly TICK_DIV cycles.
- `abort` in IDLE or FINISH: ignored.
- `abort` coinciding with a tick: abort wins, and the step does not advance.
- `cmd_valid` while busy: ignored, nothing queued; the master must hold it until `cmd_ready`.
- Latched mode/reps are not affected by input changes during RUN.

## Timing
- Reset (`rst_n` low, asynchronous): IDLE, `led`=0, `cmd_ready`=1, `busy`=0, `done`=0, all counters 0.
- Accept at edge k: at k+1 state=RUN, `busy`=1, `cmd_ready`=0, `led`=step 0 pattern.
- Each step is shown for TICK_DIV cycles.
- RUN lasts reps × period × TICK_DIV cycles. FINISH (`done`=1, `led`=0) occupies the following cycle, then IDLE with `cmd_ready`=1.
- Minimum accept-to-accept time: reps × period × TICK_DIV + 2 cycles.
- Abort sampled high at edge j in RUN: FINISH at j+1, IDLE at j+2.
- Reset mid-RUN: immediate return to reset values; no `done` pulse.

## Structure
- Shared package/header `led_seq_pkg`:
  - State encoding (IDLE, RUN, FINISH).
  - Mode codes.
  - Period lengths (2, 4, 6, 16).
  - Pattern lookup function (mode, step) → 4-bit LED value.
- Sub-module `tick_prescaler`:
  - Ports: `clk`, `rst_n`, `en`, `clr`, `tick`; parameter TICK_DIV.
  - Counter width $clog2(TICK_DIV).
- Top: FSM, step and rep counters, registered `led` output.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold `rst_n`=0 for 3 cycles → `led`=0000, `cmd_ready`=1, `busy`=0, `done`=0; same values after release with no command.
- CHASE, reps=2:
  - `led` = 0001, 0010, 0100, 1000, each held 4 cycles, sequence played twice.
  - `done` high exactly 33 cycles after the accept edge; `cmd_ready` returns one cycle later.
- BOUNCE, reps=1: `led` = 0001, 0010, 0100, 1000, 0100, 0010 (4 cycles each); one `done` pulse; then `led`=0000.
- BLINK, reps=0, `abort` pulsed after 20 cycles:
  - Before abort: alternates 0000/1111 every 4 cycles.
  - Next cycle: `done`=1, `led`=0000; then IDLE.
  - Also abort on a tick cycle → no extra step.
- Busy rejection:
  - Second command with `cmd_valid`=1 during a COUNT run → `cmd_ready`=0 and it is not taken.
  - Held valid is accepted on the first IDLE cycle with its own mode.
- Reset mid-COUNT while `led`=0101 → `led`=0000 asynchronously, no `done`; a new CHASE command then starts at 0001.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM states, pattern modes,
// period lengths and the (mode, step) -> LED lookup.
package led_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ModeBlink  = 2'd0,
    ModeChase  = 2'd1,
    ModeBounce = 2'd2,
    ModeCount  = 2'd3
  } mode_e;

  localparam logic [4:0] PeriodBlink  = 5'd2;
  localparam logic [4:0] PeriodChase  = 5'd4;
  localparam logic [4:0] PeriodBounce = 5'd6;
  localparam logic [4:0] PeriodCount  = 5'd16;

  function automatic logic [4:0] period_len(input mode_e mode);
    logic [4:0] len;
    len = PeriodCount;
    unique case (mode)
      ModeBlink:  len = PeriodBlink;
      ModeChase:  len = PeriodChase;
      ModeBounce: len = PeriodBounce;
      ModeCount:  len = PeriodCount;
      default:    len = PeriodCount;
    endcase
    return len;
  endfunction

  function automatic logic [3:0] last_step(input mode_e mode);
    return 4'(period_len(mode) - 5'd1);
  endfunction

  function automatic logic [3:0] pattern(input mode_e mode, input logic [3:0] step);
    logic [3:0] pat;
    pat = '0;
    unique case (mode)
      ModeBlink:  pat = {4{step[0]}};
      ModeChase:  pat = 4'b0001 << step[1:0];
      ModeBounce: begin
        case (step)
          4'd0:    pat = 4'b0001;
          4'd1:    pat = 4'b0010;
          4'd2:    pat = 4'b0100;
          4'd3:    pat = 4'b1000;
          4'd4:    pat = 4'b0100;
          4'd5:    pat = 4'b0010;
          default: pat = 4'b0000;
        endcase
      end
      ModeCount:  pat = step;
      default:    pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 6_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Held at zero outside RUN so a fresh command always gets a full first step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == CntMax);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Command-driven LED pattern sequencer: accepts one pattern command, plays it for
// the requested number of periods (or until abort), then pulses done.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6_250_000,
  parameter int unsigned LED_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_reps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LED_W-1:0] led
);

  state_e           state_q;
  mode_e            mode_q;
  logic [3:0]       step_q;
  logic [7:0]       rep_q;
  logic [LED_W-1:0] led_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;

  logic tick;
  logic accept;
  logic period_end;
  logic last_period;

  assign accept      = cmd_valid && ready_q;
  assign period_end  = (step_q == last_step(mode_q));
  // rep_q of zero means continuous play, so only a count of one ends the run.
  assign last_period = (rep_q == 8'd1);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == StRun),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeBlink;
      step_q  <= '0;
      rep_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StRun;
            mode_q  <= mode_e'(cmd_mode);
            step_q  <= '0;
            rep_q   <= cmd_reps;
            led_q   <= LED_W'(pattern(mode_e'(cmd_mode), 4'd0));
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        StRun: begin
          // Abort takes priority over a coincident tick: the step is not advanced.
          if (abort) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
            led_q   <= '0;
          end else if (tick && period_end && last_period) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
            led_q   <= '0;
            step_q  <= '0;
            rep_q   <= rep_q - 8'd1;
          end else if (tick && period_end) begin
            step_q <= '0;
            led_q  <= LED_W'(pattern(mode_q, 4'd0));
            if (rep_q != 8'd0) begin
              rep_q <= rep_q - 8'd1;
            end
          end else if (tick) begin
            step_q <= step_q + 4'd1;
            led_q  <= LED_W'(pattern(mode_q, step_q + 4'd1));
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          led_q   <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign led       = led_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised self-checking bench for led_pattern_sequencer, compared cycle by cycle
// against a timeline model built from the pattern tables and step duration.
module tb_led_pattern_sequencer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_reps;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] led;

  int n_vec = 0;
  int n_err = 0;

  led_pattern_sequencer #(
    .TICK_DIV (TICK),
    .LED_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .led       (led)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_period(input int m);
    case (m)
      0:       return 2;
      1:       return 4;
      2:       return 6;
      default: return 16;
    endcase
  endfunction

  function automatic logic [3:0] ref_pat(input int m, input int s);
    logic [3:0] bounce [6];
    bounce = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    case (m)
      0:       return (s % 2 == 1) ? 4'hf : 4'h0;
      1:       return 4'(1 << s);
      2:       return bounce[s];
      default: return 4'(s);
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_led"}, 32'(led), 32'(0));
    check_eq({tag, "_done"}, 32'(done), 32'(0));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      abort     = 1'($urandom % 2);
      @(negedge clk);
      check_idle("idle");
    end
    abort = 1'b0;
  endtask

  // Called on a negedge. Presents a command, follows it to the first IDLE cycle.
  task automatic do_cmd(input logic [1:0] m, input logic [7:0] r, input int abort_at,
                        input int rst_at, input bit hold, input logic [1:0] nm,
                        input logic [7:0] nr);
    int per, fin, w;
    logic [3:0] el;
    logic ed, eb, er;
    per = ref_period(int'(m));
    fin = (r != 0) ? int'(r) * per * TICK : 1_000_000;
    if (abort_at >= 0 && abort_at + 1 < fin) fin = abort_at + 1;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_reps  = r;
    abort     = 1'b0;
    w = 0;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check_eq("accept_timeout", 32'(cmd_ready), 32'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    for (int t = 0; t <= fin + 1; t++) begin
      if (t < fin) begin
        el = ref_pat(int'(m), (t / TICK) % per); ed = 1'b0; eb = 1'b1; er = 1'b0;
      end else if (t == fin) begin
        el = 4'h0; ed = 1'b1; eb = 1'b1; er = 1'b0;
      end else begin
        el = 4'h0; ed = 1'b0; eb = 1'b0; er = 1'b1;
      end
      check_eq("led", 32'(led), 32'(el));
      check_eq("done", 32'(done), 32'(ed));
      check_eq("busy", 32'(busy), 32'(eb));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(er));
      if (t == rst_at) begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        check_idle("in_rst");
        rst_n = 1'b1;
        return;
      end
      abort = (t == abort_at) || (t >= fin && ($urandom % 2 == 1));
      if (hold && t >= fin / 2) begin
        cmd_valid = 1'b1;
        cmd_mode  = nm;
        cmd_reps  = nr;
      end else if (t < fin) begin
        cmd_valid = 1'($urandom % 2);
        cmd_mode  = 2'($urandom);
        cmd_reps  = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (t <= fin) @(negedge clk);
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [1:0] m;
    logic [7:0] r;
    int         ab;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_reps  = 8'd0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    do_cmd(2'd1, 8'd2, -1, -1, 1'b0, 2'd0, 8'd0);   // CHASE x2
    idle_cycles(3);
    do_cmd(2'd2, 8'd1, -1, -1, 1'b0, 2'd0, 8'd0);   // BOUNCE x1
    idle_cycles(2);
    do_cmd(2'd0, 8'd0, 20, -1, 1'b0, 2'd0, 8'd0);   // BLINK continuous, abort
    idle_cycles(2);
    do_cmd(2'd0, 8'd0, 23, -1, 1'b0, 2'd0, 8'd0);   // abort on a tick cycle
    idle_cycles(1);
    do_cmd(2'd3, 8'd1, -1, -1, 1'b1, 2'd1, 8'd1);   // COUNT with a held next command
    do_cmd(2'd1, 8'd1, -1, -1, 1'b0, 2'd0, 8'd0);
    idle_cycles(2);
    do_cmd(2'd3, 8'd2, -1, 21, 1'b0, 2'd0, 8'd0);   // reset while led = 0101
    do_cmd(2'd1, 8'd1, -1, -1, 1'b0, 2'd0, 8'd0);
    idle_cycles(1);

    for (int i = 0; i < 16; i++) begin
      m = 2'($urandom);
      r = 8'($urandom % 4);
      if (r == 0) begin
        ab = int'($urandom_range(0, 60));
      end else if ($urandom % 3 == 0) begin
        ab = int'($urandom_range(0, int'(r) * ref_period(int'(m)) * TICK));
      end else begin
        ab = -1;
      end
      do_cmd(m, r, ab, -1, 1'b0, 2'd0, 8'd0);
      idle_cycles(int'($urandom % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
